// File: rtl/tb_lights_pkg.sv
// Shared definitions for the Thunderbird tail-light input conditioner.
// Holds the debounce state encoding and the counter-width helpers used by
// tb_debounce and tb_input_conditioner.
package tb_lights_pkg;

  // Debounce FSM states: two settled levels and the two qualifying states between them.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_t;

  // Width of a counter that must hold values up to 'cycles'.
  function automatic int db_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  // Width of a counter that runs 0..div-1.
  function automatic int tick_width(input int div);
    return $clog2(div);
  endfunction

  // Default configuration and the widths that go with it.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
  localparam int TICK_DIV_DEFAULT        = 8;
  localparam int DB_CNT_W                = db_cnt_width(DEBOUNCE_CYCLES_DEFAULT);
  localparam int TICK_W                  = tick_width(TICK_DIV_DEFAULT);

endpackage

// File: rtl/tb_debounce.sv
// One switch channel: 2-flop synchroniser followed by a debounce FSM.
// The debounced level only moves after DEBOUNCE_CYCLES consecutive
// synchronised samples at the new value; shorter excursions are dropped.
module tb_debounce
  import tb_lights_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic clear,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = db_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  db_state_t        state;
  db_state_t        state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  // Bring the asynchronous switch into the clock domain.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce state and qualification counter.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= STABLE_LO;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next state: count agreeing samples, flip on the last one, abandon on a revert.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      STABLE_LO: begin
        if (sync_q2) begin
          state_next = WAIT_HI;
          count_next = CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (!sync_q2) begin
          state_next = STABLE_LO;
          count_next = '0;
        end else if (count == CNT_LAST) begin
          state_next = STABLE_HI;
          count_next = '0;
        end else begin
          count_next = count + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!sync_q2) begin
          state_next = WAIT_LO;
          count_next = CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (sync_q2) begin
          state_next = STABLE_HI;
          count_next = '0;
        end else if (count == CNT_LAST) begin
          state_next = STABLE_LO;
          count_next = '0;
        end else begin
          count_next = count + 1'b1;
        end
      end
      default: begin
        state_next = STABLE_LO;
        count_next = '0;
      end
    endcase
  end

  // The level is high while settled high or while a drop is still being qualified.
  assign level = (state == STABLE_HI) || (state == WAIT_LO);

endmodule

// File: rtl/tb_input_conditioner.sv
// Thunderbird tail-light input conditioner.
// Debounces the left/right/hazard switches, resolves their priority and
// presents L/R/H that only change on the blink-step 'tick'.
// Build option: TB_LR_CONFLICT_HAZARD_EN -- when defined, left+right without
// hazard is reported as hazard; otherwise that combination is reported idle.
module tb_input_conditioner
  import tb_lights_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int TICK_DIV        = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic clear,
  input  logic l_raw,
  input  logic r_raw,
  input  logic h_raw,
  output logic L,
  output logic R,
  output logic H,
  output logic tick
);

  localparam int TCNT_W = tick_width(TICK_DIV);
  localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(TICK_DIV - 1);
  localparam logic [TCNT_W-1:0] TICK_PRE  = TCNT_W'(TICK_DIV - 2);

  logic              db_l;
  logic              db_r;
  logic              db_h;
  logic [TCNT_W-1:0] tick_cnt;
  logic              l_next;
  logic              r_next;
  logic              h_next;

  tb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
    .clk(clk), .clear(clear), .raw(l_raw), .level(db_l)
  );

  tb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
    .clk(clk), .clear(clear), .raw(r_raw), .level(db_r)
  );

  tb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_h (
    .clk(clk), .clear(clear), .raw(h_raw), .level(db_h)
  );

  // Step counter; tick is registered one count early so it is high exactly on the last count.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
      tick     <= (tick_cnt == TICK_PRE);
    end
  end

  // Priority resolution: hazard wins, and left+right together is a conflict.
  always_comb begin
    h_next = db_h;
    l_next = db_l & ~db_h;
    r_next = db_r & ~db_h;
`ifdef TB_LR_CONFLICT_HAZARD_EN
    if (db_l && db_r && !db_h) begin
      h_next = 1'b1;
      l_next = 1'b0;
      r_next = 1'b0;
    end
`else
    if (db_l && db_r && !db_h) begin
      l_next = 1'b0;
      r_next = 1'b0;
    end
`endif
  end

  // Requests load only at a tick so the light FSM sees them constant for a whole step.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      L <= 1'b0;
      R <= 1'b0;
      H <= 1'b0;
    end else if (tick) begin
      L <= l_next;
      R <= r_next;
      H <= h_next;
    end
  end

endmodule

// File: tb/tb_tb_input_conditioner.sv
// Self-checking bench for tb_input_conditioner (DEBOUNCE_CYCLES=4, TICK_DIV=8).
// A reference model predicts {tick,L,R,H} after every clock edge and queues it;
// an independent monitor compares the DUT against the queue on each falling edge.
module tb_tb_input_conditioner;

  localparam int DB = 4;
  localparam int TD = 8;

  logic clk = 1'b0;
  logic clear;
  logic l_raw;
  logic r_raw;
  logic h_raw;
  logic L;
  logic R;
  logic H;
  logic tick;

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] exp_q[$];

  int edge_cnt;
  bit raw_log[3][$];
  bit obs_log[3][$];
  bit lvl[3];
  bit out_l;
  bit out_r;
  bit out_h;

  tb_input_conditioner #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)) dut (
    .clk(clk), .clear(clear),
    .l_raw(l_raw), .r_raw(r_raw), .h_raw(h_raw),
    .L(L), .R(R), .H(H), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got tick/L/R/H=%b, expected %b", name, $time, actual, expected);
    end
  endtask

  task automatic model_reset();
    edge_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      raw_log[i].delete();
      obs_log[i].delete();
      lvl[i] = 1'b0;
    end
    out_l = 1'b0;
    out_r = 1'b0;
    out_h = 1'b0;
  endtask

  // One clock edge of the reference model; raw_now = {h,r,l}.
  task automatic model_edge(input bit [2:0] raw_now);
    bit tick_before;
    bit hh;
    bit ll;
    bit rr;
    bit obs;
    bit steady;
    tick_before = (edge_cnt % TD) == TD - 1;
    edge_cnt++;
    if (tick_before) begin
      hh = lvl[2];
      ll = lvl[0] & ~hh;
      rr = lvl[1] & ~hh;
      if (lvl[0] && lvl[1] && !hh) begin
`ifdef TB_LR_CONFLICT_HAZARD_EN
        hh = 1'b1;
`endif
        ll = 1'b0;
        rr = 1'b0;
      end
      out_l = ll;
      out_r = rr;
      out_h = hh;
    end
    for (int i = 0; i < 3; i++) begin
      raw_log[i].push_back(raw_now[i]);
      obs = (edge_cnt >= 3) ? raw_log[i][edge_cnt-3] : 1'b0;
      obs_log[i].push_back(obs);
      if (edge_cnt >= DB) begin
        steady = 1'b1;
        for (int j = edge_cnt - DB; j < edge_cnt; j++)
          if (obs_log[i][j] != obs) steady = 1'b0;
        if (steady) lvl[i] = obs;
      end
    end
    exp_q.push_back({((edge_cnt % TD) == TD - 1), out_l, out_r, out_h});
  endtask

  task automatic applyStimulus(input bit l, input bit r, input bit h, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      l_raw = l;
      r_raw = r;
      h_raw = h;
      @(posedge clk);
      model_edge({h, r, l});
      @(negedge clk);
    end
  endtask

  // Monitor: every falling edge with a prediction pending, compare it.
  always @(negedge clk) begin
    if (clear && exp_q.size() > 0)
      checkOutput("cycle", {tick, L, R, H}, exp_q.pop_front());
  end

  initial begin
    logic [2:0] pat;
    logic [2:0] bits;
    int len;
    bit noisy;

    model_reset();
    clear = 1'b0;
    l_raw = 1'b0;
    r_raw = 1'b0;
    h_raw = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_state", {tick, L, R, H}, 4'b0000);
    #2 clear = 1'b1;

    $display("[TB] idle and clean left press");
    applyStimulus(0, 0, 0, 10);
    applyStimulus(1, 0, 0, 24);
    applyStimulus(0, 0, 0, 20);

    $display("[TB] bouncing right switch");
    for (int b = 0; b < 6; b++) begin
      applyStimulus(0, 1, 0, 3);
      applyStimulus(0, 0, 0, 3);
    end

    $display("[TB] hazard priority over left");
    applyStimulus(1, 0, 1, 20);
    applyStimulus(1, 0, 0, 24);
    applyStimulus(0, 0, 0, 20);

    $display("[TB] left/right conflict");
    applyStimulus(1, 1, 0, 24);
    applyStimulus(0, 0, 0, 20);

    $display("[TB] debounce against every tick phase");
    for (int p = 0; p < 8; p++) begin
      applyStimulus(0, 0, 0, 1);
      applyStimulus(1, 0, 0, 16);
      applyStimulus(0, 0, 0, 16);
    end

    $display("[TB] asynchronous clear mid-run");
    applyStimulus(0, 0, 1, 30);
    #2 clear = 1'b0;
    #1 checkOutput("async_clear", {tick, L, R, H}, 4'b0000);
    @(posedge clk);
    #1 checkOutput("clear_held", {tick, L, R, H}, 4'b0000);
    @(negedge clk);
    #2 clear = 1'b1;
    model_reset();
    applyStimulus(0, 0, 1, 20);
    applyStimulus(0, 0, 0, 20);

    $display("[TB] randomized switch activity");
    for (int s = 0; s < 40; s++) begin
      pat   = 3'($urandom_range(0, 7));
      len   = $urandom_range(1, 24);
      noisy = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < len; c++) begin
        bits = pat;
        if (noisy) bits = bits ^ (3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)));
        applyStimulus(bits[0], bits[1], bits[2], 1);
      end
    end
    applyStimulus(0, 0, 0, 20);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
